// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions.
// Contents:
//   - major opcode constants (LUI .. SYS)
//   - NOP encoding (all-zero word, used as the pipeline bubble)
//   - imm_type_e: immediate format selector
//   - id_ex_t: the ID/EX pipeline payload
//   - imm_type_of / imm_gen: opcode-to-format map and immediate builder
package rv32_pkg;

    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BCC   = 7'b1100011;
    localparam logic [6:0] LCC   = 7'b0000011;
    localparam logic [6:0] SCC   = 7'b0100011;
    localparam logic [6:0] MCC   = 7'b0010011;
    localparam logic [6:0] RCC   = 7'b0110011;
    localparam logic [6:0] SYS   = 7'b1110011;

    localparam logic [31:0] NOP = 32'd0;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic        mem_read;
    } id_ex_t;

    function automatic imm_type_e imm_type_of(input logic [6:0] op);
        imm_type_e t;
        case (op)
            LCC, MCC, JALR, SYS: t = IMM_I;
            SCC:                 t = IMM_S;
            BCC:                 t = IMM_B;
            LUI, AUIPC:          t = IMM_U;
            JAL:                 t = IMM_J;
            default:             t = IMM_NONE;  // RCC and unknown opcodes
        endcase
        return t;
    endfunction

    // All formats sign-extend from inst[31]; B and J carry an implicit 0 LSB.
    function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_type_e t);
        logic [31:0] imm;
        case (t)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'd0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: NREGS x XLEN, two combinational read ports,
// one synchronous write port.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high clear of every register
//   i_ra1, i_ra2       read addresses
//   o_rd1, o_rd2       read data (x0 reads 0; same-cycle write is bypassed)
//   i_we, i_wa, i_wd   write enable / address / data (writes to x0 dropped)
module regfile_2r1w #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [$clog2(NREGS)-1:0] i_ra1,
    input  logic [$clog2(NREGS)-1:0] i_ra2,
    output logic [XLEN-1:0]          o_rd1,
    output logic [XLEN-1:0]          o_rd2,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_wa,
    input  logic [XLEN-1:0]          i_wd
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_en;

    assign w_wr_en = i_we && (i_wa != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Write-through: a decode reading the register being written back this
    // cycle sees the new value without waiting for the flop.
    always_comb begin
        o_rd1 = r_regs[i_ra1];
        if (i_ra1 == '0) begin
            o_rd1 = '0;
        end else if (w_wr_en && (i_wa == i_ra1)) begin
            o_rd1 = i_wd;
        end
    end

    always_comb begin
        o_rd2 = r_regs[i_ra2];
        if (i_ra2 == '0) begin
            o_rd2 = '0;
        end else if (w_wr_en && (i_wa == i_ra2)) begin
            o_rd2 = i_wd;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage.
// Takes the fetched instruction (or the locally held replay copy), reads the
// register file, builds the immediate, detects load-use hazards and registers
// the ID/EX payload.
// Ports:
//   CLK, RES                    clock, synchronous active-high reset
//   IF_ID_pc, IF_ID_inst        instruction from fetch (inst 0 = bubble)
//   branch_taken                flush from EX
//   stall                       freeze all decode state
//   wb_we, wb_rd, wb_data       register-file write-back
//   Load_bubble                 combinational load-use hazard to fetch
//   ID_EX_*                     registered decode payload for EX
module decode_stage
    import rv32_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic [XLEN-1:0] IF_ID_pc,
    input  logic [31:0]     IF_ID_inst,
    input  logic            branch_taken,
    input  logic            stall,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            Load_bubble,
    output logic            ID_EX_valid,
    output logic [XLEN-1:0] ID_EX_pc,
    output logic [6:0]      ID_EX_opcode,
    output logic [2:0]      ID_EX_funct3,
    output logic            ID_EX_funct7b5,
    output logic [4:0]      ID_EX_rs1,
    output logic [4:0]      ID_EX_rs2,
    output logic [4:0]      ID_EX_rd,
    output logic [XLEN-1:0] ID_EX_rs1_data,
    output logic [XLEN-1:0] ID_EX_rs2_data,
    output logic [XLEN-1:0] ID_EX_imm,
    output logic            ID_EX_mem_read
);

    logic            r_replay_valid;
    logic [31:0]     r_hold_inst;
    logic [XLEN-1:0] r_hold_pc;
    id_ex_t          r_ex_p1;

    logic [31:0]     w_inst_p0;
    logic [XLEN-1:0] w_pc_p0;
    logic [6:0]      w_op_p0;
    logic [4:0]      w_rs1_p0;
    logic [4:0]      w_rs2_p0;
    logic            w_uses_rs1_p0;
    logic            w_uses_rs2_p0;
    logic [XLEN-1:0] w_rs1_data_p0;
    logic [XLEN-1:0] w_rs2_data_p0;
    id_ex_t          w_dec_p0;
    logic            w_load_bubble;

    // ---- decode (p0): source select, operand read, field decode ----
    // The replay copy wins because fetch has zeroed IF_ID_inst while it waits.
    assign w_inst_p0 = r_replay_valid ? r_hold_inst : IF_ID_inst;
    assign w_pc_p0   = r_replay_valid ? r_hold_pc   : IF_ID_pc;
    assign w_op_p0   = w_inst_p0[6:0];
    assign w_rs1_p0  = w_inst_p0[19:15];
    assign w_rs2_p0  = w_inst_p0[24:20];

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .i_clk (CLK),
        .i_rst (RES),
        .i_ra1 (w_rs1_p0),
        .i_ra2 (w_rs2_p0),
        .o_rd1 (w_rs1_data_p0),
        .o_rd2 (w_rs2_data_p0),
        .i_we  (wb_we),
        .i_wa  (wb_rd),
        .i_wd  (wb_data)
    );

    assign w_uses_rs1_p0 = !((w_op_p0 == LUI) || (w_op_p0 == AUIPC) || (w_op_p0 == JAL));
    assign w_uses_rs2_p0 = (w_op_p0 == BCC) || (w_op_p0 == SCC) || (w_op_p0 == RCC);

    always_comb begin
        w_dec_p0          = '0;
        w_dec_p0.valid    = (w_inst_p0 != NOP);
        w_dec_p0.pc       = w_pc_p0;
        w_dec_p0.opcode   = w_op_p0;
        w_dec_p0.funct3   = w_inst_p0[14:12];
        w_dec_p0.funct7b5 = w_inst_p0[30];
        w_dec_p0.rs1      = w_rs1_p0;
        w_dec_p0.rs2      = w_rs2_p0;
        // Stores and branches reuse inst[11:7] as immediate bits, not a destination.
        w_dec_p0.rd       = ((w_op_p0 == SCC) || (w_op_p0 == BCC)) ? 5'd0 : w_inst_p0[11:7];
        w_dec_p0.rs1_data = w_rs1_data_p0;
        w_dec_p0.rs2_data = w_rs2_data_p0;
        w_dec_p0.imm      = imm_gen(w_inst_p0, imm_type_of(w_op_p0));
        w_dec_p0.mem_read = (w_op_p0 == LCC);
    end

    // A load in EX cannot forward in time to a dependent instruction in ID.
    // The replayed copy never re-triggers: ID_EX is a bubble by then.
    assign Load_bubble = r_ex_p1.valid && r_ex_p1.mem_read && (r_ex_p1.rd != 5'd0)
                       && ((w_uses_rs1_p0 && (w_rs1_p0 == r_ex_p1.rd))
                        || (w_uses_rs2_p0 && (w_rs2_p0 == r_ex_p1.rd)))
                       && !branch_taken && !stall;

    // ---- ID/EX boundary (p1) ----
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_ex_p1        <= '0;
            r_ex_p1.pc     <= RESET_PC;
            r_replay_valid <= 1'b0;
        end else if (!stall) begin
            if (branch_taken) begin
                r_ex_p1        <= '0;
                r_replay_valid <= 1'b0;
            end else if (Load_bubble) begin
                r_ex_p1        <= '0;
                r_hold_inst    <= w_inst_p0;
                r_hold_pc      <= w_pc_p0;
                r_replay_valid <= 1'b1;
            end else begin
                r_ex_p1        <= w_dec_p0;
                r_replay_valid <= 1'b0;
            end
        end
    end

    assign ID_EX_valid    = r_ex_p1.valid;
    assign ID_EX_pc       = r_ex_p1.pc;
    assign ID_EX_opcode   = r_ex_p1.opcode;
    assign ID_EX_funct3   = r_ex_p1.funct3;
    assign ID_EX_funct7b5 = r_ex_p1.funct7b5;
    assign ID_EX_rs1      = r_ex_p1.rs1;
    assign ID_EX_rs2      = r_ex_p1.rs2;
    assign ID_EX_rd       = r_ex_p1.rd;
    assign ID_EX_rs1_data = r_ex_p1.rs1_data;
    assign ID_EX_rs2_data = r_ex_p1.rs2_data;
    assign ID_EX_imm      = r_ex_p1.imm;
    assign ID_EX_mem_read = r_ex_p1.mem_read;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        RES;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        branch_taken;
    logic        stall;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        Load_bubble;
    logic        ID_EX_valid;
    logic [31:0] ID_EX_pc;
    logic [6:0]  ID_EX_opcode;
    logic [2:0]  ID_EX_funct3;
    logic        ID_EX_funct7b5;
    logic [4:0]  ID_EX_rs1;
    logic [4:0]  ID_EX_rs2;
    logic [4:0]  ID_EX_rd;
    logic [31:0] ID_EX_rs1_data;
    logic [31:0] ID_EX_rs2_data;
    logic [31:0] ID_EX_imm;
    logic        ID_EX_mem_read;

    int n_cmp = 0;
    int n_err = 0;

    decode_stage dut (
        .CLK            (CLK),
        .RES            (RES),
        .IF_ID_pc       (IF_ID_pc),
        .IF_ID_inst     (IF_ID_inst),
        .branch_taken   (branch_taken),
        .stall          (stall),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .Load_bubble    (Load_bubble),
        .ID_EX_valid    (ID_EX_valid),
        .ID_EX_pc       (ID_EX_pc),
        .ID_EX_opcode   (ID_EX_opcode),
        .ID_EX_funct3   (ID_EX_funct3),
        .ID_EX_funct7b5 (ID_EX_funct7b5),
        .ID_EX_rs1      (ID_EX_rs1),
        .ID_EX_rs2      (ID_EX_rs2),
        .ID_EX_rd       (ID_EX_rd),
        .ID_EX_rs1_data (ID_EX_rs1_data),
        .ID_EX_rs2_data (ID_EX_rs2_data),
        .ID_EX_imm      (ID_EX_imm),
        .ID_EX_mem_read (ID_EX_mem_read)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        mrd;
    } ex_t;

    ex_t         m_ex;
    logic [31:0] m_rf [32];
    logic        m_replay;
    logic [31:0] m_hold_inst;
    logic [31:0] m_hold_pc;
    logic        m_known = 1'b0;

    function automatic logic [31:0] src_inst();
        return m_replay ? m_hold_inst : IF_ID_inst;
    endfunction

    function automatic logic [31:0] src_pc();
        return m_replay ? m_hold_pc : IF_ID_pc;
    endfunction

    // Architectural register read as seen by decode, including the write landing now.
    function automatic logic [31:0] arch_reg(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_we && wb_rd == idx) return wb_data;
        return m_rf[idx];
    endfunction

    function automatic ex_t model_issue(input logic [31:0] inst, input logic [31:0] pc);
        ex_t e;
        e.valid  = (inst != 32'd0);
        e.pc     = pc;
        e.opcode = inst[6:0];
        e.f3     = inst[14:12];
        e.f7b5   = inst[30];
        e.rs1    = inst[19:15];
        e.rs2    = inst[24:20];
        e.rd     = (inst[6:0] == 7'h23 || inst[6:0] == 7'h63) ? 5'd0 : inst[11:7];
        e.d1     = arch_reg(inst[19:15]);
        e.d2     = arch_reg(inst[24:20]);
        e.mrd    = (inst[6:0] == 7'h03);
        case (inst[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: e.imm = 32'($signed(inst[31:20]));
            7'h23: e.imm = 32'($signed({inst[31:25], inst[11:7]}));
            7'h63: e.imm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            7'h37, 7'h17: e.imm = {inst[31:12], 12'h000};
            7'h6F: e.imm = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            default: e.imm = 32'd0;
        endcase
        return e;
    endfunction

    // Load in EX whose destination the decoding instruction actually reads.
    function automatic logic model_lb();
        logic [31:0] inst;
        logic [6:0]  op;
        logic        r1, r2;
        inst = src_inst();
        op   = inst[6:0];
        r1   = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        r2   = (op == 7'h63 || op == 7'h23 || op == 7'h33);
        return m_ex.valid && m_ex.mrd && m_ex.rd != 5'd0
            && ((r1 && inst[19:15] == m_ex.rd) || (r2 && inst[24:20] == m_ex.rd))
            && !branch_taken && !stall;
    endfunction

    always @(posedge CLK) begin
        if (RES) begin
            m_ex     <= '0;
            m_replay <= 1'b0;
            m_known  <= 1'b1;
            for (int i = 0; i < 32; i++) m_rf[i] <= 32'd0;
        end else begin
            if (!stall) begin
                if (branch_taken) begin
                    m_ex     <= '0;
                    m_replay <= 1'b0;
                end else if (model_lb()) begin
                    m_ex        <= '0;
                    m_hold_inst <= src_inst();
                    m_hold_pc   <= src_pc();
                    m_replay    <= 1'b1;
                end else begin
                    m_ex     <= model_issue(src_inst(), src_pc());
                    m_replay <= 1'b0;
                end
            end
            if (wb_we && wb_rd != 5'd0) m_rf[wb_rd] <= wb_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every negedge once the model state is defined.
    always @(negedge CLK) begin
        if (m_known) begin
            chk("Load_bubble", 32'(Load_bubble), 32'(model_lb()));
            chk("valid",    32'(ID_EX_valid),    32'(m_ex.valid));
            chk("pc",       ID_EX_pc,            m_ex.pc);
            chk("opcode",   32'(ID_EX_opcode),   32'(m_ex.opcode));
            chk("funct3",   32'(ID_EX_funct3),   32'(m_ex.f3));
            chk("funct7b5", 32'(ID_EX_funct7b5), 32'(m_ex.f7b5));
            chk("rs1",      32'(ID_EX_rs1),      32'(m_ex.rs1));
            chk("rs2",      32'(ID_EX_rs2),      32'(m_ex.rs2));
            chk("rd",       32'(ID_EX_rd),       32'(m_ex.rd));
            chk("rs1_data", ID_EX_rs1_data,      m_ex.d1);
            chk("rs2_data", ID_EX_rs2_data,      m_ex.d2);
            chk("imm",      ID_EX_imm,           m_ex.imm);
            chk("mem_read", 32'(ID_EX_mem_read), 32'(m_ex.mrd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic [31:0] inst, input logic [31:0] pc,
                          input logic br = 1'b0, input logic st = 1'b0,
                          input logic we = 1'b0, input logic [4:0] rd = 5'd0,
                          input logic [31:0] d = 32'd0);
        IF_ID_inst   = inst;
        IF_ID_pc     = pc;
        branch_taken = br;
        stall        = st;
        wb_we        = we;
        wb_rd        = rd;
        wb_data      = d;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    localparam logic [31:0] ADDI_M1  = 32'hFFF00093; // addi x1,x0,-1
    localparam logic [31:0] ADDI_X3  = 32'h00018213; // addi x4,x3,0
    localparam logic [31:0] ADDI_X0  = 32'h00000213; // addi x4,x0,0
    localparam logic [31:0] LW_X5    = 32'h00012283; // lw x5,0(x2)
    localparam logic [31:0] ADD_X5   = 32'h00728333; // add x6,x5,x7
    localparam logic [31:0] SW_X5    = 32'h00512023; // sw x5,0(x2)
    localparam logic [31:0] ADDI_X10 = 32'h00050593; // addi x11,x10,0
    localparam logic [31:0] SW_8     = 32'h00712423; // sw x7,8(x2)
    localparam logic [31:0] BEQ_M4   = 32'hFE208EE3; // beq x1,x2,-4
    localparam logic [31:0] LUI_X9   = 32'h123454B7; // lui x9,0x12345
    localparam logic [31:0] JAL_16   = 32'h010000EF; // jal x1,+16
    localparam logic [31:0] AUIPC_X2 = 32'hFFFFF117; // auipc x2,0xFFFFF
    localparam logic [31:0] UNK      = 32'h0000057F; // unknown opcode, rd x10

    logic [31:0] tbl [16] = '{ADDI_M1, ADDI_X3, ADDI_X0, LW_X5, ADD_X5, SW_X5, ADDI_X10, SW_8,
                              BEQ_M4, LUI_X9, JAL_16, AUIPC_X2, UNK, LW_X5, SW_X5, 32'd0};

    initial begin
        // 1. reset
        set_in(ADDI_M1, 32'h44);
        RES = 1'b1;
        tick();
        tick();
        RES = 1'b0;
        set_in(32'd0, 32'd0);
        tick();
        chk("rst valid", 32'(ID_EX_valid), 32'd0);
        chk("rst pc", ID_EX_pc, 32'd0);
        chk("rst imm", ID_EX_imm, 32'd0);
        chk("rst Load_bubble", 32'(Load_bubble), 32'd0);

        // 2. addi x1,x0,-1
        set_in(ADDI_M1, 32'h10);
        tick();
        chk("addi imm", ID_EX_imm, 32'hFFFFFFFF);
        chk("addi rd", 32'(ID_EX_rd), 32'd1);
        chk("addi valid", 32'(ID_EX_valid), 32'd1);
        chk("addi pc", ID_EX_pc, 32'h10);

        // 4. write-back bypass and x0
        set_in(ADDI_X3, 32'h14, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF);
        tick();
        chk("bypass rs1_data", ID_EX_rs1_data, 32'hDEADBEEF);
        set_in(ADDI_X0, 32'h18, 1'b0, 1'b0, 1'b1, 5'd0, 32'h00001234);
        tick();
        chk("x0 same-cycle", ID_EX_rs1_data, 32'd0);
        set_in(ADDI_X0, 32'h1C);
        tick();
        chk("x0 after write", ID_EX_rs1_data, 32'd0);
        set_in(ADDI_X3, 32'h20);
        tick();
        chk("x3 stored", ID_EX_rs1_data, 32'hDEADBEEF);

        // 3. load-use with replay
        set_in(LW_X5, 32'h24);
        tick();
        chk("lw mem_read", 32'(ID_EX_mem_read), 32'd1);
        set_in(ADD_X5, 32'h28);
        #1 chk("lu Load_bubble", 32'(Load_bubble), 32'd1);
        tick();
        chk("lu bubble valid", 32'(ID_EX_valid), 32'd0);
        set_in(32'd0, 32'h2C);
        #1 chk("replay no hazard", 32'(Load_bubble), 32'd0);
        tick();
        chk("replay valid", 32'(ID_EX_valid), 32'd1);
        chk("replay pc", ID_EX_pc, 32'h28);
        chk("replay rd", 32'(ID_EX_rd), 32'd6);

        // load-use through rs2 of a store
        set_in(LW_X5, 32'h2C);
        tick();
        set_in(SW_X5, 32'h30);
        #1 chk("rs2 Load_bubble", 32'(Load_bubble), 32'd1);
        tick();
        set_in(32'd0, 32'h34);
        tick();
        chk("sw replay pc", ID_EX_pc, 32'h30);

        // 5. flush beats load-use
        set_in(LW_X5, 32'h38);
        tick();
        set_in(ADD_X5, 32'h3C, 1'b1);
        #1 chk("flush Load_bubble", 32'(Load_bubble), 32'd0);
        tick();
        chk("flush valid", 32'(ID_EX_valid), 32'd0);
        set_in(ADDI_M1, 32'h40);
        tick();
        chk("post-flush pc", ID_EX_pc, 32'h40);

        // 6. stall for 3 cycles with a WB write in the middle
        set_in(ADD_X5, 32'h54, 1'b0, 1'b1, 1'b1, 5'd10, 32'h0000CAFE);
        tick();
        chk("stall1 pc", ID_EX_pc, 32'h40);
        set_in(ADD_X5, 32'h54, 1'b0, 1'b1);
        tick();
        tick();
        chk("stall3 pc", ID_EX_pc, 32'h40);
        chk("stall3 imm", ID_EX_imm, 32'hFFFFFFFF);
        set_in(ADDI_X10, 32'h58);
        tick();
        chk("post-stall x10", ID_EX_rs1_data, 32'h0000CAFE);

        // stall masks the hazard; it fires once released
        set_in(LW_X5, 32'h60);
        tick();
        set_in(ADD_X5, 32'h64, 1'b0, 1'b1);
        #1 chk("stall masks hazard", 32'(Load_bubble), 32'd0);
        tick();
        set_in(ADD_X5, 32'h64);
        #1 chk("hazard after stall", 32'(Load_bubble), 32'd1);
        tick();
        set_in(32'd0, 32'h68);
        tick();
        chk("stall replay pc", ID_EX_pc, 32'h64);

        // immediate formats
        set_in(SW_8, 32'h70);
        tick();
        chk("S imm", ID_EX_imm, 32'd8);
        chk("S rd", 32'(ID_EX_rd), 32'd0);
        set_in(BEQ_M4, 32'h74);
        tick();
        chk("B imm", ID_EX_imm, 32'hFFFFFFFC);
        set_in(LUI_X9, 32'h78);
        tick();
        chk("U imm", ID_EX_imm, 32'h12345000);
        set_in(JAL_16, 32'h7C);
        tick();
        chk("J imm", ID_EX_imm, 32'h00000010);
        set_in(AUIPC_X2, 32'h80);
        tick();
        chk("AUIPC imm", ID_EX_imm, 32'hFFFFF000);
        set_in(UNK, 32'h84);
        tick();
        chk("unknown imm", ID_EX_imm, 32'd0);
        chk("unknown valid", 32'(ID_EX_valid), 32'd1);
        set_in(ADD_X5, 32'h88);
        tick();
        chk("R imm", ID_EX_imm, 32'd0);

        // mixed traffic, model-checked every cycle
        for (int i = 0; i < 60; i++) begin
            set_in(tbl[$urandom_range(0, 15)], 32'(i * 4 + 32'h100),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom());
            tick();
        end

        set_in(32'd0, 32'd0);
        tick();
        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
